// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86 instruction codes and architectural register IDs
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] ICMOVQ  = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam int unsigned RRSP = 4;

endpackage

// File: rtl/regfile_2w2r.sv
// rtl/regfile_2w2r.sv - two-write two-read register file with M-port write priority
module regfile_2w2r #(
  parameter int DATA_W     = 64,
  parameter int REG_AW     = 4,
  parameter int NUM_REGS   = 15,
  parameter int RESET_INIT = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [REG_AW-1:0] wr_e_id,
  input  logic [DATA_W-1:0] wr_e_data,
  input  logic [REG_AW-1:0] wr_m_id,
  input  logic [DATA_W-1:0] wr_m_data,
  input  logic [REG_AW-1:0] rd_a_id,
  output logic [DATA_W-1:0] rd_a_data,
  input  logic [REG_AW-1:0] rd_b_id,
  output logic [DATA_W-1:0] rd_b_data
);

  localparam int NSLOT = 1 << REG_AW;

  // Sized to the full ID space so any ID indexes cleanly; slots >= NUM_REGS stay constant.
  logic [DATA_W-1:0] regs [NSLOT];

  logic wr_e_ok, wr_m_ok;
  assign wr_e_ok = (int'(wr_e_id) < NUM_REGS);
  assign wr_m_ok = (int'(wr_m_id) < NUM_REGS);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NSLOT; i++) begin
        regs[i] <= (RESET_INIT != 0 && i < NUM_REGS) ? DATA_W'(i) : '0;
      end
    end else begin
      if (wr_e_ok) regs[wr_e_id] <= wr_e_data;
      // Later assignment wins, so a same-register collision takes the M data.
      if (wr_m_ok) regs[wr_m_id] <= wr_m_data;
    end
  end

  assign rd_a_data = (int'(rd_a_id) < NUM_REGS) ? regs[rd_a_id] : '0;
  assign rd_b_data = (int'(rd_b_id) < NUM_REGS) ? regs[rd_b_id] : '0;

endmodule

// File: rtl/decode_regfile_fwd.sv
// rtl/decode_regfile_fwd.sv - Y86 decode/writeback with forwarding, load-use detect and E register
module decode_regfile_fwd
  import y86_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int REG_AW     = 4,
  parameter int NUM_REGS   = 15,
  parameter int RESET_INIT = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [3:0]        D_icode_i,
  input  logic [REG_AW-1:0] D_rA_i,
  input  logic [REG_AW-1:0] D_rB_i,
  input  logic [DATA_W-1:0] D_valC_i,
  input  logic [DATA_W-1:0] D_valP_i,
  input  logic [REG_AW-1:0] e_dstE_i,
  input  logic [DATA_W-1:0] e_valE_i,
  input  logic [REG_AW-1:0] M_dstM_i,
  input  logic [DATA_W-1:0] m_valM_i,
  input  logic [REG_AW-1:0] M_dstE_i,
  input  logic [DATA_W-1:0] M_valE_i,
  input  logic [REG_AW-1:0] W_dstM_i,
  input  logic [REG_AW-1:0] W_dstE_i,
  input  logic [DATA_W-1:0] W_valM_i,
  input  logic [DATA_W-1:0] W_valE_i,
  input  logic [3:0]        E_icode_q_i,
  input  logic [REG_AW-1:0] E_dstM_q_i,
  input  logic              e_stall_i,
  input  logic              e_bubble_i,
  output logic              d_load_use_o,
  output logic [3:0]        E_icode_o,
  output logic [DATA_W-1:0] E_valA_o,
  output logic [DATA_W-1:0] E_valB_o,
  output logic [DATA_W-1:0] E_valC_o,
  output logic [REG_AW-1:0] E_dstE_o,
  output logic [REG_AW-1:0] E_dstM_o,
  output logic [REG_AW-1:0] E_srcA_o,
  output logic [REG_AW-1:0] E_srcB_o
);

  localparam logic [REG_AW-1:0] RNONE = '1;
  localparam logic [REG_AW-1:0] RSP   = REG_AW'(RRSP);

  logic [REG_AW-1:0] d_srcA, d_srcB, d_dstE, d_dstM;
  logic [DATA_W-1:0] rf_a, rf_b, d_valA, d_valB;

  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;
    case (D_icode_i)
      ICMOVQ:  begin d_srcA = D_rA_i; d_dstE = D_rB_i; end
      IIRMOVQ: begin d_dstE = D_rB_i; end
      IRMMOVQ: begin d_srcA = D_rA_i; d_srcB = D_rB_i; end
      IMRMOVQ: begin d_srcB = D_rB_i; d_dstM = D_rA_i; end
      IOPQ:    begin d_srcA = D_rA_i; d_srcB = D_rB_i; d_dstE = D_rB_i; end
      ICALL:   begin d_srcB = RSP; d_dstE = RSP; end
      IRET:    begin d_srcA = RSP; d_srcB = RSP; d_dstE = RSP; end
      IPUSHQ:  begin d_srcA = D_rA_i; d_srcB = RSP; d_dstE = RSP; end
      IPOPQ:   begin d_srcA = RSP; d_srcB = RSP; d_dstE = RSP; d_dstM = D_rA_i; end
      default: ;
    endcase
  end

  regfile_2w2r #(
    .DATA_W    (DATA_W),
    .REG_AW    (REG_AW),
    .NUM_REGS  (NUM_REGS),
    .RESET_INIT(RESET_INIT)
  ) u_rf (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .wr_e_id  (W_dstE_i),
    .wr_e_data(W_valE_i),
    .wr_m_id  (W_dstM_i),
    .wr_m_data(W_valM_i),
    .rd_a_id  (d_srcA),
    .rd_a_data(rf_a),
    .rd_b_id  (d_srcB),
    .rd_b_data(rf_b)
  );

  // Youngest producer first; W sources also cover the same-cycle write/read case.
  function automatic logic [DATA_W-1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                                input logic [DATA_W-1:0] rf_val);
    if (src == RNONE)         return '0;
    else if (src == e_dstE_i) return e_valE_i;
    else if (src == M_dstM_i) return m_valM_i;
    else if (src == M_dstE_i) return M_valE_i;
    else if (src == W_dstM_i) return W_valM_i;
    else if (src == W_dstE_i) return W_valE_i;
    else                      return rf_val;
  endfunction

  always_comb begin
    d_valB = fwd_sel(d_srcB, rf_b);
    if (D_icode_i == ICALL || D_icode_i == IJXX) d_valA = D_valP_i;
    else                                         d_valA = fwd_sel(d_srcA, rf_a);
  end

  assign d_load_use_o = (E_icode_q_i == IMRMOVQ || E_icode_q_i == IPOPQ) &&
                        (E_dstM_q_i != RNONE) &&
                        (E_dstM_q_i == d_srcA || E_dstM_q_i == d_srcB);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || (!e_stall_i && (e_bubble_i || d_load_use_o))) begin
      E_icode_o <= INOP;
      E_valA_o  <= '0;
      E_valB_o  <= '0;
      E_valC_o  <= '0;
      E_dstE_o  <= RNONE;
      E_dstM_o  <= RNONE;
      E_srcA_o  <= RNONE;
      E_srcB_o  <= RNONE;
    end else if (!e_stall_i) begin
      E_icode_o <= D_icode_i;
      E_valA_o  <= d_valA;
      E_valB_o  <= d_valB;
      E_valC_o  <= D_valC_i;
      E_dstE_o  <= d_dstE;
      E_dstM_o  <= d_dstM;
      E_srcA_o  <= d_srcA;
      E_srcB_o  <= d_srcB;
    end
  end

endmodule

// File: tb/tb_decode_regfile_fwd.sv
// tb/tb_decode_regfile_fwd.sv - directed table plus randomized reference-model bench
module tb_decode_regfile_fwd;
  import y86_pkg::*;

  localparam logic [3:0] NONE = 4'hF;
  localparam logic [3:0] SP   = 4'h4;

  typedef struct {
    logic [3:0]  icode, rA, rB;
    logic [63:0] valC, valP;
    logic [3:0]  e_dstE;  logic [63:0] e_valE;
    logic [3:0]  M_dstM;  logic [63:0] m_valM;
    logic [3:0]  M_dstE;  logic [63:0] M_valE;
    logic [3:0]  W_dstM, W_dstE;
    logic [63:0] W_valM, W_valE;
    logic [3:0]  E_icode_q, E_dstM_q;
    logic        stall, bubble, rst_n;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic        chk;
    logic [3:0]  icode;
    logic [63:0] va, vb;
    logic [3:0]  dste;
    logic        lu;
  } rec_t;

  typedef struct {
    logic [3:0]  icode;
    logic [63:0] va, vb, vc;
    logic [3:0]  dste, dstm, srca, srcb;
  } ereg_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, bubble;
  logic [3:0]  D_icode, D_rA, D_rB, e_dstE, M_dstM, M_dstE, W_dstM, W_dstE, E_icode_q, E_dstM_q;
  logic [63:0] D_valC, D_valP, e_valE, m_valM, M_valE, W_valM, W_valE;

  logic        lu, z_lu;
  logic [3:0]  E_icode, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [3:0]  z_icode, z_dstE, z_dstM, z_srcA, z_srcB;
  logic [63:0] E_valA, E_valB, E_valC, z_valA, z_valB, z_valC;

  decode_regfile_fwd #(.RESET_INIT(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .D_icode_i(D_icode), .D_rA_i(D_rA), .D_rB_i(D_rB),
    .D_valC_i(D_valC), .D_valP_i(D_valP), .e_dstE_i(e_dstE), .e_valE_i(e_valE),
    .M_dstM_i(M_dstM), .m_valM_i(m_valM), .M_dstE_i(M_dstE), .M_valE_i(M_valE),
    .W_dstM_i(W_dstM), .W_dstE_i(W_dstE), .W_valM_i(W_valM), .W_valE_i(W_valE),
    .E_icode_q_i(E_icode_q), .E_dstM_q_i(E_dstM_q), .e_stall_i(stall), .e_bubble_i(bubble),
    .d_load_use_o(lu), .E_icode_o(E_icode), .E_valA_o(E_valA), .E_valB_o(E_valB),
    .E_valC_o(E_valC), .E_dstE_o(E_dstE), .E_dstM_o(E_dstM), .E_srcA_o(E_srcA), .E_srcB_o(E_srcB)
  );

  decode_regfile_fwd #(.RESET_INIT(0)) dut_z (
    .clk_i(clk), .rst_n_i(rst_n), .D_icode_i(D_icode), .D_rA_i(D_rA), .D_rB_i(D_rB),
    .D_valC_i(D_valC), .D_valP_i(D_valP), .e_dstE_i(e_dstE), .e_valE_i(e_valE),
    .M_dstM_i(M_dstM), .m_valM_i(m_valM), .M_dstE_i(M_dstE), .M_valE_i(M_valE),
    .W_dstM_i(W_dstM), .W_dstE_i(W_dstE), .W_valM_i(W_valM), .W_valE_i(W_valE),
    .E_icode_q_i(E_icode_q), .E_dstM_q_i(E_dstM_q), .e_stall_i(stall), .e_bubble_i(bubble),
    .d_load_use_o(z_lu), .E_icode_o(z_icode), .E_valA_o(z_valA), .E_valB_o(z_valB),
    .E_valC_o(z_valC), .E_dstE_o(z_dstE), .E_dstM_o(z_dstM), .E_srcA_o(z_srcA), .E_srcB_o(z_srcB)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [63:0] mrf [16];
  ereg_t me;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t idle();
    vec_t v;
    v.icode = INOP; v.rA = NONE; v.rB = NONE; v.valC = 0; v.valP = 0;
    v.e_dstE = NONE; v.e_valE = 0; v.M_dstM = NONE; v.m_valM = 0;
    v.M_dstE = NONE; v.M_valE = 0; v.W_dstM = NONE; v.W_dstE = NONE;
    v.W_valM = 0; v.W_valE = 0; v.E_icode_q = INOP; v.E_dstM_q = NONE;
    v.stall = 0; v.bubble = 0; v.rst_n = 1;
    return v;
  endfunction

  function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] rA);
    if (ic inside {ICMOVQ, IRMMOVQ, IOPQ, IPUSHQ}) return rA;
    if (ic inside {IPOPQ, IRET}) return SP;
    return NONE;
  endfunction

  function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rB);
    if (ic inside {IOPQ, IRMMOVQ, IMRMOVQ}) return rB;
    if (ic inside {ICALL, IPUSHQ, IPOPQ, IRET}) return SP;
    return NONE;
  endfunction

  function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic [3:0] rB);
    if (ic inside {ICMOVQ, IIRMOVQ, IOPQ}) return rB;
    if (ic inside {IPUSHQ, IPOPQ, ICALL, IRET}) return SP;
    return NONE;
  endfunction

  function automatic logic [3:0] m_dstM(input logic [3:0] ic, input logic [3:0] rA);
    return (ic inside {IMRMOVQ, IPOPQ}) ? rA : NONE;
  endfunction

  function automatic logic [63:0] m_read(input vec_t v, input logic [3:0] src);
    logic [3:0]  dsts [5];
    logic [63:0] vals [5];
    if (src == NONE) return 0;
    dsts = '{v.e_dstE, v.M_dstM, v.M_dstE, v.W_dstM, v.W_dstE};
    vals = '{v.e_valE, v.m_valM, v.M_valE, v.W_valM, v.W_valE};
    for (int k = 0; k < 5; k++) if (dsts[k] == src) return vals[k];
    return (src < 15) ? mrf[src] : 64'h0;
  endfunction

  task automatic step(input vec_t v);
    logic [3:0] sa, sb;
    logic       exp_lu;
    D_icode = v.icode; D_rA = v.rA; D_rB = v.rB; D_valC = v.valC; D_valP = v.valP;
    e_dstE = v.e_dstE; e_valE = v.e_valE; M_dstM = v.M_dstM; m_valM = v.m_valM;
    M_dstE = v.M_dstE; M_valE = v.M_valE; W_dstM = v.W_dstM; W_dstE = v.W_dstE;
    W_valM = v.W_valM; W_valE = v.W_valE; E_icode_q = v.E_icode_q; E_dstM_q = v.E_dstM_q;
    stall = v.stall; bubble = v.bubble; rst_n = v.rst_n;
    #1;
    sa = m_srcA(v.icode, v.rA);
    sb = m_srcB(v.icode, v.rB);
    exp_lu = (v.E_icode_q inside {IMRMOVQ, IPOPQ}) && v.E_dstM_q != NONE &&
             (v.E_dstM_q == sa || v.E_dstM_q == sb);
    chk("model_load_use", {63'h0, lu}, {63'h0, exp_lu});
    if (!v.rst_n || (!v.stall && (v.bubble || exp_lu))) begin
      me = '{INOP, 0, 0, 0, NONE, NONE, NONE, NONE};
    end else if (!v.stall) begin
      me.icode = v.icode;
      me.va    = (v.icode inside {ICALL, IJXX}) ? v.valP : m_read(v, sa);
      me.vb    = m_read(v, sb);
      me.vc    = v.valC;
      me.dste  = m_dstE(v.icode, v.rB);
      me.dstm  = m_dstM(v.icode, v.rA);
      me.srca  = sa;
      me.srcb  = sb;
    end
    if (!v.rst_n) begin
      for (int i = 0; i < 16; i++) mrf[i] = (i < 15) ? 64'(i) : 64'h0;
    end else begin
      if (v.W_dstE < 15) mrf[v.W_dstE] = v.W_valE;
      if (v.W_dstM < 15) mrf[v.W_dstM] = v.W_valM;
    end
    @(posedge clk);
    #1;
    chk("model_icode", {60'h0, E_icode}, {60'h0, me.icode});
    chk("model_valA", E_valA, me.va);
    chk("model_valB", E_valB, me.vb);
    chk("model_valC", E_valC, me.vc);
    chk("model_dstE", {60'h0, E_dstE}, {60'h0, me.dste});
    chk("model_dstM", {60'h0, E_dstM}, {60'h0, me.dstm});
    chk("model_srcA", {60'h0, E_srcA}, {60'h0, me.srca});
    chk("model_srcB", {60'h0, E_srcB}, {60'h0, me.srcb});
  endtask

  rec_t tbl [13];

  initial begin
    vec_t v;
    for (int i = 0; i < 13; i++) begin
      tbl[i].v = idle(); tbl[i].chk = 1'b1; tbl[i].icode = INOP;
      tbl[i].va = 0; tbl[i].vb = 0; tbl[i].dste = NONE; tbl[i].lu = 1'b0;
    end
    // 0: reset
    tbl[0].v.rst_n = 0;
    // 1: plain OPQ
    tbl[1].v.icode = IOPQ; tbl[1].v.rA = 2; tbl[1].v.rB = 3;
    tbl[1].icode = IOPQ; tbl[1].va = 2; tbl[1].vb = 3; tbl[1].dste = 3;
    // 2: e beats M and W
    tbl[2].v.icode = IOPQ; tbl[2].v.rA = 5; tbl[2].v.rB = 0;
    tbl[2].v.e_dstE = 5; tbl[2].v.e_valE = 64'hAA; tbl[2].v.M_dstE = 5; tbl[2].v.M_valE = 64'hBB;
    tbl[2].v.W_dstE = 5; tbl[2].v.W_valE = 64'hCC;
    tbl[2].icode = IOPQ; tbl[2].va = 64'hAA; tbl[2].vb = 0; tbl[2].dste = 0;
    // 3: without e, M wins
    tbl[3].v = tbl[2].v; tbl[3].v.e_dstE = NONE;
    tbl[3].icode = IOPQ; tbl[3].va = 64'hBB; tbl[3].vb = 0; tbl[3].dste = 0;
    // 4: write-port collision on reg 4
    tbl[4].v.W_dstE = 4; tbl[4].v.W_valE = 64'h11; tbl[4].v.W_dstM = 4; tbl[4].v.W_valM = 64'h22;
    // 5: read back reg 4
    tbl[5].v.icode = IOPQ; tbl[5].v.rA = 4; tbl[5].v.rB = 1;
    tbl[5].icode = IOPQ; tbl[5].va = 64'h22; tbl[5].vb = 1; tbl[5].dste = 1;
    // 6: load-use bubble
    tbl[6].v.icode = IOPQ; tbl[6].v.rA = 7; tbl[6].v.rB = 1;
    tbl[6].v.E_icode_q = IMRMOVQ; tbl[6].v.E_dstM_q = 7; tbl[6].lu = 1'b1;
    // 7: load a known E value
    tbl[7].v.icode = IOPQ; tbl[7].v.rA = 2; tbl[7].v.rB = 3;
    tbl[7].icode = IOPQ; tbl[7].va = 2; tbl[7].vb = 3; tbl[7].dste = 3;
    // 8: load-use with stall holds E
    tbl[8].v = tbl[6].v; tbl[8].v.stall = 1'b1; tbl[8].lu = 1'b1;
    tbl[8].icode = IOPQ; tbl[8].va = 2; tbl[8].vb = 3; tbl[8].dste = 3;
    // 9: CALL valP and forwarded RSP
    tbl[9].v.icode = ICALL; tbl[9].v.valP = 64'h40; tbl[9].v.e_dstE = SP; tbl[9].v.e_valE = 64'h1F8;
    tbl[9].icode = ICALL; tbl[9].va = 64'h40; tbl[9].vb = 64'h1F8; tbl[9].dste = SP;
    // 10: unknown icode with reg 1 write
    tbl[10].v.icode = 4'hC; tbl[10].v.rA = 1; tbl[10].v.rB = 2; tbl[10].v.valP = 64'h5;
    tbl[10].v.W_dstE = 1; tbl[10].v.W_valE = 64'h99;
    tbl[10].icode = 4'hC;
    // 11: mid-run reset drops the reg 2 write
    tbl[11].v.rst_n = 0; tbl[11].v.W_dstE = 2; tbl[11].v.W_valE = 64'h55;
    // 12: regs back at init values
    tbl[12].v.icode = IOPQ; tbl[12].v.rA = 1; tbl[12].v.rB = 2;
    tbl[12].icode = IOPQ; tbl[12].va = 1; tbl[12].vb = 2; tbl[12].dste = 2;

    for (int i = 0; i < 16; i++) mrf[i] = 0;
    me = '{INOP, 0, 0, 0, NONE, NONE, NONE, NONE};
    @(posedge clk);
    #1;
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].v);
      if (tbl[i].chk) begin
        chk($sformatf("tbl%0d_load_use", i), {63'h0, lu}, {63'h0, tbl[i].lu});
        chk($sformatf("tbl%0d_icode", i), {60'h0, E_icode}, {60'h0, tbl[i].icode});
        chk($sformatf("tbl%0d_valA", i), E_valA, tbl[i].va);
        chk($sformatf("tbl%0d_valB", i), E_valB, tbl[i].vb);
        chk($sformatf("tbl%0d_dstE", i), {60'h0, E_dstE}, {60'h0, tbl[i].dste});
      end
    end
    chk("rinit0_valA", z_valA, 64'h0);
    chk("rinit0_valB", z_valB, 64'h0);

    for (int n = 0; n < 400; n++) begin
      v = idle();
      v.icode = 4'($urandom_range(0, 15));
      v.rA = 4'($urandom_range(0, 15));
      v.rB = 4'($urandom_range(0, 15));
      v.valC = {$urandom, $urandom};
      v.valP = {$urandom, $urandom};
      v.e_dstE = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : NONE;
      v.M_dstM = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : NONE;
      v.M_dstE = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : NONE;
      v.W_dstM = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : NONE;
      v.W_dstE = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : NONE;
      v.e_valE = {$urandom, $urandom};
      v.m_valM = {$urandom, $urandom};
      v.M_valE = {$urandom, $urandom};
      v.W_valM = {$urandom, $urandom};
      v.W_valE = {$urandom, $urandom};
      v.E_icode_q = ($urandom_range(0, 1) == 0) ? IMRMOVQ :
                    ($urandom_range(0, 1) == 0) ? IPOPQ : 4'($urandom_range(0, 15));
      v.E_dstM_q = 4'($urandom_range(0, 15));
      v.stall  = ($urandom_range(0, 9) == 0);
      v.bubble = ($urandom_range(0, 9) == 0);
      v.rst_n  = ($urandom_range(0, 49) != 0);
      step(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
